// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared constants for the NoC clock-domain-crossing blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    // Legal depth range of a synchronizing flop chain
    localparam int   SYNC_MIN_STAGES = 2;
    localparam int   SYNC_MAX_STAGES = 4;

    // Default per-lane value loaded into chain and history flops on reset
    localparam logic SYNC_RESET_VAL  = 1'b0;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/sync_lane.sv
`default_nettype none
// ============================================================================
//  Module      : sync_lane
//  Description : Single-bit multi-flop synchronizer with one-cycle history
//                flop and registered toggle/rise/fall detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_lane
    import noc_pkg::*;
#(
    parameter int   STAGES    = SYNC_MIN_STAGES,
    parameter logic RESET_VAL = SYNC_RESET_VAL
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_dout,
    output logic o_toggle,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_hist;
    logic              w_toggle;

    // Shift the asynchronous input through the chain and keep the previous
    // synchronized value; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {STAGES{RESET_VAL}};
            r_hist  <= RESET_VAL;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_din};
            r_hist  <= r_chain[STAGES-1];
        end
    end

    // Outputs depend only on flops, so din never reaches an output directly
    assign w_toggle = r_chain[STAGES-1] ^ r_hist;
    assign o_dout   = r_chain[STAGES-1];
    assign o_toggle = w_toggle;
    assign o_rise   = w_toggle &  r_chain[STAGES-1];
    assign o_fall   = w_toggle & ~r_chain[STAGES-1];

endmodule : sync_lane
`default_nettype wire

// File: rtl/cdc_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_synchronizer
//  Description : WIDTH independent single-bit synchronizers bringing
//                toggle-signalled lines into the clk domain, with per-lane
//                change detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_synchronizer
    import noc_pkg::*;
#(
    parameter int   WIDTH     = 1,
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = SYNC_RESET_VAL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] dout_toggle,
    output logic [WIDTH-1:0] dout_rise,
    output logic [WIDTH-1:0] dout_fall
);

    // Reject chain depths outside the supported range at elaboration
    generate
        if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
            $fatal(1, "cdc_synchronizer: STAGES=%0d outside %0d..%0d",
                   STAGES, SYNC_MIN_STAGES, SYNC_MAX_STAGES);
        end
    endgenerate

    // Lanes are synchronized independently; no bus coherency is implied
    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_lane
            sync_lane #(
                .STAGES    (STAGES),
                .RESET_VAL (RESET_VAL)
            ) u_lane (
                .clk      (clk),
                .rst      (reset),
                .i_din    (din[g]),
                .o_dout   (dout[g]),
                .o_toggle (dout_toggle[g]),
                .o_rise   (dout_rise[g]),
                .o_fall   (dout_fall[g])
            );
        end
    endgenerate

endmodule : cdc_synchronizer
`default_nettype wire

// File: tb/tb_cdc_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdc_synchronizer
//  Description : Self-checking bench for cdc_synchronizer (4-lane STAGES=2
//                and 1-lane STAGES=3 instances) against an edge-history model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_synchronizer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] din4 = 4'b0000;
    logic       din3 = 1'b0;

    logic [3:0] dout4, tog4, rise4, fall4;
    logic       dout3, tog3, rise3, fall3;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    cdc_synchronizer #(.WIDTH(4), .STAGES(2), .RESET_VAL(1'b0)) dut (
        .clk(clk), .reset(reset), .din(din4),
        .dout(dout4), .dout_toggle(tog4), .dout_rise(rise4), .dout_fall(fall4)
    );

    cdc_synchronizer #(.WIDTH(1), .STAGES(3), .RESET_VAL(1'b0)) dut3 (
        .clk(clk), .reset(reset), .din(din3),
        .dout(dout3), .dout_toggle(tog3), .dout_rise(rise3), .dout_fall(fall3)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: record of everything sampled at each edge ----
    typedef struct packed {
        logic       rst;
        logic [3:0] d4;
        logic       d3;
    } rec_t;

    rec_t hist[$];
    int   first_rst = -1;

    always @(posedge clk) begin
        hist.push_back('{rst: reset, d4: din4, d3: din3});
        if (reset && first_rst < 0) first_rst = hist.size() - 1;
    end

    // Output after edge n is the input sampled STAGES-1 edges earlier, or
    // the reset value if any reset edge fell inside that window.
    function automatic logic [3:0] exp_dout(int n, int stages, bit sel3);
        for (int k = n - stages + 1; k <= n; k++)
            if (k >= 0 && hist[k].rst) return 4'b0000;
        return sel3 ? {3'b000, hist[n - stages + 1].d3} : hist[n - stages + 1].d4;
    endfunction

    // Value one cycle earlier as seen by the change detector
    function automatic logic [3:0] exp_prev(int n, int stages, bit sel3);
        if (hist[n].rst) return 4'b0000;
        return exp_dout(n - 1, stages, sel3);
    endfunction

    bit jitter_on = 1'b0;
    int out_toggles = 0;

    // Per-cycle comparison against the model once a reset has been seen
    always @(negedge clk) begin
        int n;
        logic [3:0] e4, p4, t4, e3, p3, t3;
        n = hist.size() - 1;
        if (first_rst >= 0 && n > first_rst) begin
            e4 = exp_dout(n, 2, 1'b0);
            p4 = exp_prev(n, 2, 1'b0);
            t4 = e4 ^ p4;
            e3 = exp_dout(n, 3, 1'b1);
            p3 = exp_prev(n, 3, 1'b1);
            t3 = e3 ^ p3;
            check("model_dout4", dout4, e4);
            check("model_tog4",  tog4,  t4);
            check("model_rise4", rise4, t4 & e4);
            check("model_fall4", fall4, t4 & ~e4);
            check("model_dout3", {3'b000, dout3}, e3);
            check("model_tog3",  {3'b000, tog3},  t3);
            check("model_rise3", {3'b000, rise3}, t3 & e3);
            check("model_fall3", {3'b000, fall3}, t3 & ~e3);
        end
        if (jitter_on) out_toggles += $countones(tog4) + $countones({3'b000, tog3});
    end

    // Advance one edge, ending at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int in_toggles = 0;

    initial begin
        logic [3:0] mask;
        @(negedge clk);

        // Reset held with din high: outputs stay at reset value
        reset = 1'b1; din4 = 4'b0001; din3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_dout",  dout4, 4'b0000);
            check("rst_tog",   tog4,  4'b0000);
            check("rst_dout3", {3'b000, dout3}, 4'b0000);
        end

        // Release: single rise two edges later (three for STAGES=3)
        reset = 1'b0;
        step();
        check("rel_dout_A", dout4, 4'b0000);
        check("rel_tog_A",  tog4,  4'b0000);
        step();
        check("rel_dout_A1", dout4, 4'b0001);
        check("rel_tog_A1",  tog4,  4'b0001);
        check("rel_rise_A1", rise4, 4'b0001);
        check("rel_dout3_A1", {3'b000, dout3}, 4'b0000);
        step();
        check("rel_tog_A2",   tog4, 4'b0000);
        check("rel_dout3_A2", {3'b000, dout3}, 4'b0001);
        check("rel_tog3_A2",  {3'b000, tog3},  4'b0001);
        step();
        check("rel_tog3_A3",  {3'b000, tog3},  4'b0000);

        // Back-to-back toggles on lane 0
        din4 = 4'b0000; step();
        check("b2b_dout_e", dout4, 4'b0001);
        din4 = 4'b0001; step();
        check("b2b_dout_e1", dout4, 4'b0000);
        check("b2b_fall_e1", fall4, 4'b0001);
        din4 = 4'b0000; step();
        check("b2b_dout_e2", dout4, 4'b0001);
        check("b2b_rise_e2", rise4, 4'b0001);
        check("b2b_fall_e2", fall4, 4'b0000);
        step();
        check("b2b_dout_e3", dout4, 4'b0000);
        check("b2b_fall_e3", fall4, 4'b0001);
        check("b2b_tog_e3",  tog4,  4'b0001);
        step();
        check("b2b_tog_e4",  tog4,  4'b0000);

        // Reset while a rise is in flight
        din4 = 4'b0001; step();
        reset = 1'b1; step();
        check("mid_dout_k1", dout4, 4'b0000);
        check("mid_tog_k1",  tog4,  4'b0000);
        reset = 1'b0; step();
        check("mid_dout_k2", dout4, 4'b0000);
        check("mid_tog_k2",  tog4,  4'b0000);
        step();
        check("mid_dout_k3", dout4, 4'b0001);
        check("mid_rise_k3", rise4, 4'b0001);

        // Multi-lane pattern
        din4 = 4'b0000; step(); step(); step();
        din4 = 4'b1010; step();
        check("ml_dout_k", dout4, 4'b0000);
        step();
        check("ml_dout_k1", dout4, 4'b1010);
        check("ml_rise_k1", rise4, 4'b1010);
        check("ml_fall_k1", fall4, 4'b0000);
        step();
        check("ml_rise_k2", rise4, 4'b0000);

        // Random-phase toggles, spaced well apart
        step(); step();
        jitter_on = 1'b1;
        for (int ev = 0; ev < 1000; ev++) begin
            @(posedge clk);
            #($urandom_range(1, 9));
            mask = 4'($urandom_range(1, 15));
            din4 = din4 ^ mask;
            din3 = ~din3;
            in_toggles += $countones(mask) + 1;
            repeat ($urandom_range(4, 6)) @(posedge clk);
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        jitter_on = 1'b0;
        check("jit_count_lo", 4'(out_toggles), 4'(in_toggles));
        tests++;
        if (out_toggles != in_toggles) begin
            failed++;
            $display("FAIL jit_count: got %0d toggles expected %0d", out_toggles, in_toggles);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_cdc_synchronizer
`default_nettype wire
